// File: rtl/board_pkg.sv
// Shared constants, FSM state type and tile-to-ASCII mapping for the board
// text formatter that feeds the UART transmit path.
package board_pkg;

  localparam int TILE_W     = 4;
  localparam int BOARD_DIM  = 4;
  localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM * TILE_W;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_ESC    = 8'h1B;
  localparam logic [7:0] ASCII_LBRACK = 8'h5B;
  localparam logic [7:0] ASCII_H      = 8'h48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOME,
    ST_TILE,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_FIN
  } fmt_state_e;

  // One hex digit per tile; exponent 0 is an empty square.
  function automatic logic [7:0] exp_to_ascii(input logic [TILE_W-1:0] e,
                                              input logic [7:0] empty_char);
    logic [7:0] ch;
    ch = empty_char;
    if (e >= 4'd10) begin
      ch = 8'h41 + ({4'h0, e} - 8'd10);
    end else if (e != 4'd0) begin
      ch = 8'h30 + {4'h0, e};
    end
    return ch;
  endfunction

  function automatic logic [TILE_W-1:0] tile_exp(input logic [BOARD_BITS-1:0] board,
                                                 input logic [1:0] r,
                                                 input logic [1:0] c);
    return board[{r, c, 2'b00} +: TILE_W];
  endfunction

endpackage

// File: rtl/tx_strobe_gate.sv
// Issues one-cycle transmit strobes toward uart_top and tells the formatter
// when the presented byte has been taken.
module tx_strobe_gate (
  input  logic clk,
  input  logic rst,
  input  logic i_byte_valid,
  input  logic i_tx_busy,
  output logic o_tx_stb,
  output logic o_adv
);

  // Handshake: a byte is offered while i_byte_valid=1 and o_tx_data is stable.
  // A strobe is issued only when uart_top reports not busy and the guard is
  // clear; the guard covers the cycle after a strobe, before uart_top's
  // registered busy can reflect it. o_adv pulses in the strobe cycle so the
  // formatter moves to the next byte on the closing edge.
  logic stb_q, stb_d;
  logic guard_q, guard_d;

  always_comb begin
    stb_d   = i_byte_valid & ~i_tx_busy & ~guard_q & ~stb_q;
    guard_d = stb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q   <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      stb_q   <= stb_d;
      guard_q <= guard_d;
    end
  end

  assign o_tx_stb = stb_q;
  assign o_adv    = stb_q;

endmodule

// File: rtl/board_tx_fmt.sv
// Snapshots a 4x4 board on i_start and streams its ASCII rendering, one byte
// per strobe, with an optional VT100 cursor-home prefix.
module board_tx_fmt
  import board_pkg::*;
#(
  parameter bit         HOME_EN    = 1'b1,
  parameter logic [7:0] EMPTY_CHAR = 8'h2E,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [BOARD_BITS-1:0] i_board,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_stb,
  input  logic                  i_tx_busy
);

  fmt_state_e            state_q, state_d;
  logic [1:0]            row_q, row_d;
  logic [1:0]            col_q, col_d;
  logic [1:0]            idx_q, idx_d;
  logic [BOARD_BITS-1:0] snap_q, snap_d;
  logic [7:0]            data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  byte_valid;
  logic                  adv;
  logic [1:0]            col_inc;
  logic [1:0]            row_inc;

  assign byte_valid = (state_q == ST_HOME) || (state_q == ST_TILE) ||
                      (state_q == ST_SEP)  || (state_q == ST_CR)   ||
                      (state_q == ST_LF);
  assign col_inc = col_q + 2'd1;
  assign row_inc = row_q + 2'd1;

  // data_q always holds the byte for the current pointer, so each transition
  // loads the byte belonging to the state being entered.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          snap_d = i_board;
          busy_d = 1'b1;
          row_d  = 2'd0;
          col_d  = 2'd0;
          idx_d  = 2'd0;
          if (HOME_EN) begin
            state_d = ST_HOME;
            data_d  = ASCII_ESC;
          end else begin
            state_d = ST_TILE;
            data_d  = exp_to_ascii(tile_exp(i_board, 2'd0, 2'd0), EMPTY_CHAR);
          end
        end
      end
      ST_HOME: begin
        if (adv) begin
          if (idx_q == 2'd2) begin
            state_d = ST_TILE;
            data_d  = exp_to_ascii(tile_exp(snap_q, 2'd0, 2'd0), EMPTY_CHAR);
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = (idx_q == 2'd0) ? ASCII_LBRACK : ASCII_H;
          end
        end
      end
      ST_TILE: begin
        if (adv) begin
          if (col_q == 2'd3) begin
            state_d = ST_CR;
            data_d  = ASCII_CR;
          end else begin
            state_d = ST_SEP;
            data_d  = SEP_CHAR;
          end
        end
      end
      ST_SEP: begin
        if (adv) begin
          col_d   = col_inc;
          state_d = ST_TILE;
          data_d  = exp_to_ascii(tile_exp(snap_q, row_q, col_inc), EMPTY_CHAR);
        end
      end
      ST_CR: begin
        if (adv) begin
          state_d = ST_LF;
          data_d  = ASCII_LF;
        end
      end
      ST_LF: begin
        if (adv) begin
          col_d = 2'd0;
          row_d = row_inc;
          if (row_q == 2'd3) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_TILE;
            data_d  = exp_to_ascii(tile_exp(snap_q, row_inc, 2'd0), EMPTY_CHAR);
          end
        end
      end
      ST_FIN: begin
        // First FIN cycle covers the last strobe's guard; done shows in the second.
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      idx_q   <= 2'd0;
      snap_q  <= '0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  tx_strobe_gate u_gate (
    .clk          (clk),
    .rst          (rst),
    .i_byte_valid (byte_valid),
    .i_tx_busy    (i_tx_busy),
    .o_tx_stb     (o_tx_stb),
    .o_adv        (adv)
  );

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_tx_data = data_q;

endmodule

// File: tb/tb_board_tx_fmt.sv
// Bench for board_tx_fmt: a HOME_EN=1 instance for the main frames and a
// HOME_EN=0 instance for back-to-back frames with i_start held high.
module tb_board_tx_fmt;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [63:0] i_board;
  logic        o_busy, o_done, o_tx_stb;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;

  logic        b_start;
  logic [63:0] b_board;
  logic        b_busy, b_done, b_stb;
  logic [7:0]  b_data;
  logic        b_tx_busy;

  int tests;
  int fails;
  int cyc;
  int busy_mode;
  int exp_done;
  int b_exp_done;
  logic [7:0] exp_q[$];
  logic [7:0] b_exp_q[$];

  board_tx_fmt #(.HOME_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_board(i_board),
    .o_busy(o_busy), .o_done(o_done), .o_tx_data(o_tx_data),
    .o_tx_stb(o_tx_stb), .i_tx_busy(i_tx_busy)
  );

  board_tx_fmt #(.HOME_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_start(b_start), .i_board(b_board),
    .o_busy(b_busy), .o_done(b_done), .o_tx_data(b_data),
    .o_tx_stb(b_stb), .i_tx_busy(b_tx_busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] m_char(input logic [3:0] e);
    string hex;
    hex = "0123456789ABCDEF";
    if (e == 4'd0) return 8'h2E;
    return hex[e];
  endfunction

  task automatic push_board(input logic [63:0] bd, input bit home, input bit to_b);
    logic [7:0] seq[$];
    if (home) begin
      seq.push_back(8'h1B); seq.push_back(8'h5B); seq.push_back(8'h48);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        seq.push_back(m_char(bd[4*(4*r+c) +: 4]));
        if (c < 3) seq.push_back(8'h20);
      end
      seq.push_back(8'h0D);
      seq.push_back(8'h0A);
    end
    foreach (seq[i]) begin
      if (to_b) b_exp_q.push_back(seq[i]);
      else exp_q.push_back(seq[i]);
    end
  endtask

  // ---------------- UART busy model ----------------
  // Registered like uart_top: rises the cycle after a strobe.
  initial begin
    int hold;
    int n_stb;
    logic seen;
    hold = 0;
    n_stb = 0;
    i_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      seen = o_tx_stb;
      #1;
      if (rst) begin
        hold = 0;
      end else if (seen) begin
        n_stb = n_stb + 1;
        if (busy_mode != 0 && (n_stb % 5) == 0) hold = 20;
      end else if (hold > 0) begin
        hold = hold - 1;
      end
      i_tx_busy = (hold > 0);
    end
  end

  // ---------------- monitors ----------------
  initial begin
    int last_cyc;
    bit have_last;
    have_last = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_tx_stb) begin
          chk("stb_while_busy", 64'(i_tx_busy), 64'd0);
          if (have_last) chk("stb_spacing_ge2", 64'(cyc - last_cyc >= 2), 64'd1);
          last_cyc = cyc;
          have_last = 1;
          if (exp_q.size() == 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL unexpected_strobe: got %0h expected no strobe", o_tx_data);
          end else begin
            chk("tx_byte", 64'(o_tx_data), 64'(exp_q.pop_front()));
          end
        end
        if (o_done) begin
          if (exp_done == 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL unexpected_done: got pulse expected none");
          end else begin
            exp_done = exp_done - 1;
            chk("done_after_last_byte", 64'(exp_q.size()), 64'd0);
          end
          chk("busy_low_at_done", 64'(o_busy), 64'd0);
        end
      end
    end
  end

  initial begin
    int last_cyc;
    bit have_last;
    have_last = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (b_stb) begin
          if (have_last) chk("b_stb_spacing_ge2", 64'(cyc - last_cyc >= 2), 64'd1);
          last_cyc = cyc;
          have_last = 1;
          if (b_exp_q.size() == 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL b_unexpected_strobe: got %0h expected no strobe", b_data);
          end else begin
            chk("b_tx_byte", 64'(b_data), 64'(b_exp_q.pop_front()));
          end
        end
        if (b_done) begin
          if (b_exp_done == 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL b_unexpected_done: got pulse expected none");
          end else begin
            b_exp_done = b_exp_done - 1;
            chk("b_bytes_left_at_done", 64'(b_exp_q.size()), 64'(36 * b_exp_done));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  task automatic wait_frame(input string nm, input int exp_len, input int budget);
    int n;
    bit got;
    n = 0;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_tx_stb) n = n + 1;
      if (o_done) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    if (exp_len > 0) chk({nm, "_frame_len"}, 64'(n), 64'(exp_len));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    tests = 0;
    fails = 0;
    busy_mode = 0;
    exp_done = 0;
    b_exp_done = 0;
    rst = 1'b1;
    i_start = 1'b0;
    i_board = '0;
    b_start = 1'b0;
    b_board = '0;
    b_tx_busy = 1'b0;
    idle(3);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_stb", 64'(o_tx_stb), 64'd0);
    chk("rst_data", 64'(o_tx_data), 64'h00);
    rst = 1'b0;
    idle(2);

    // T1: empty board, literal expected frame
    exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h48);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back(8'h2E);
        exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h2E); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
    exp_done = 1;
    i_board = '0;
    pulse_start();
    wait_frame("t1", 39, 1000);
    idle(5);

    // T2: (0,0)=11 'B', (1,2)=9 '9', (3,3)=15 'F'
    i_board = 64'hF000_0000_0900_000B;
    push_board(i_board, 1'b1, 1'b0);
    exp_done = 1;
    pulse_start();
    wait_frame("t2", 39, 1000);
    idle(5);

    // T3: UART busy 20 cycles after every 5th strobe
    busy_mode = 1;
    i_board = '0;
    push_board(i_board, 1'b1, 1'b0);
    exp_done = 1;
    pulse_start();
    wait_frame("t3", 39, 3000);
    busy_mode = 0;
    idle(25);

    // T4: board changed and start re-pulsed mid-frame
    i_board = 64'h0123_4567_89AB_CDEF;
    push_board(i_board, 1'b1, 1'b0);
    exp_done = 1;
    pulse_start();
    n = 0;
    for (int i = 0; i < 500 && n < 8; i++) begin
      @(negedge clk);
      if (o_tx_stb) n = n + 1;
    end
    i_board = ~i_board;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_frame("t4", 0, 1000);
    idle(60);
    chk("t4_single_done", 64'(exp_done), 64'd0);

    // T5: reset after the 10th strobe, then a fresh frame
    i_board = 64'h1111_2222_3333_4444;
    push_board(i_board, 1'b1, 1'b0);
    exp_done = 1;
    pulse_start();
    n = 0;
    for (int i = 0; i < 500 && n < 10; i++) begin
      @(negedge clk);
      if (o_tx_stb) n = n + 1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t5_stb_after_rst", 64'(o_tx_stb), 64'd0);
    chk("t5_busy_after_rst", 64'(o_busy), 64'd0);
    exp_q.delete();
    exp_done = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    i_board = '0;
    push_board(i_board, 1'b1, 1'b0);
    exp_done = 1;
    pulse_start();
    wait_frame("t5", 39, 1000);
    idle(5);

    // T6: HOME_EN=0, start held high for three back-to-back frames
    b_board = 64'hFEDC_BA98_7654_3210;
    for (int f = 0; f < 3; f++) push_board(b_board, 1'b0, 1'b1);
    b_exp_done = 3;
    @(negedge clk);
    b_start = 1'b1;
    n = 0;
    for (int i = 0; i < 2000 && n < 3; i++) begin
      @(negedge clk);
      if (b_done) n = n + 1;
    end
    b_start = 1'b0;
    chk("t6_frames_done", 64'(n), 64'd3);
    idle(40);
    chk("t6_bytes_left", 64'(b_exp_q.size()), 64'd0);
    chk("t6_done_left", 64'(b_exp_done), 64'd0);

    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("final_done_left", 64'(exp_done), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
